tiny_sig_monitor: RTL and testbench

//  Passive bus snooper for tiny_thumb_core simulations, replacing fixed-cycle single-word checks.
//  - Watches the unified memory bus between core and tiny_mem_model.
//  - Captures NUM_SIGS signature words and detects a program "done" write.
//  - Enforces a watchdog; reports sticky pass/fail, a per-channel fail mask and a cycle count.
//  - Never drives the bus.

---
 rtl/tiny_sig_monitor.sv | 193 +++++++++++++++++++
 tb/tb_tiny_sig_monitor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tiny_sig_monitor.sv
// -----------------------------------------------------------------------------
// tiny_sig_monitor
// Passive snooper for the unified core <-> memory bus in tiny_thumb_core
// simulations. It shadows writes to NUM_SIGS signature words, watches for the
// program's exit-code ("done") write, runs a watchdog, and reports a sticky
// pass/fail verdict with a per-channel fail mask and a RUN cycle count.
// The monitor only observes the bus; it never drives it.
//
// Ports
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   mem_valid/we/ready  snooped handshake; a transfer completes on valid&ready
//   mem_addr/wdata/wstrb snooped byte address, write data and byte strobes
//   sig_expected        expected words, channel i in [32*i+31:32*i]
//   sig_enable          per-channel check enable, sampled only in CHECK
//   done/pass/fail      sticky verdict flags
//   timeout, bad_exit   sticky failure causes (watchdog / exit code != 1)
//   fail_mask           enabled channels that mismatched or were never written
//   cycle_count         RUN cycles elapsed, frozen once the run ends
// -----------------------------------------------------------------------------
module tiny_sig_monitor #(
   parameter int          NUM_SIGS       = 4,
   parameter logic [31:0] SIG_BASE       = 32'h0000_0100,
   parameter logic [31:0] DONE_ADDR      = 32'h0000_01FC,
   parameter int          TIMEOUT_CYCLES = 1000,
   parameter int          CNT_W          = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_valid,
   input  logic                   mem_we,
   input  logic [31:0]            mem_addr,
   input  logic [31:0]            mem_wdata,
   input  logic [3:0]             mem_wstrb,
   input  logic                   mem_ready,
   input  logic [32*NUM_SIGS-1:0] sig_expected,
   input  logic [NUM_SIGS-1:0]    sig_enable,
   output logic                   done,
   output logic                   pass,
   output logic                   fail,
   output logic                   timeout,
   output logic                   bad_exit,
   output logic [NUM_SIGS-1:0]    fail_mask,
   output logic [CNT_W-1:0]       cycle_count
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_CHECK = 2'd1,
      ST_PASS  = 2'd2,
      ST_FAIL  = 2'd3
   } state_t;

   // Last RUN-counter value before expiry; the watchdog uses its own counter
   // so it is unaffected by cycle_count wrapping when CNT_W is narrow.
   localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t              state_r;
   logic [31:0]         shadow_r [NUM_SIGS];
   logic [NUM_SIGS-1:0] seen_r;
   logic [31:0]         wd_cnt_r;

   logic                wr_hit_s;
   logic                done_hit_s;
   logic                wd_expire_s;
   logic [NUM_SIGS-1:0] chan_hit_s;
   logic [NUM_SIGS-1:0] mask_s;
   logic                unused_s;

   // Byte-lane merge: strobed lanes take the new data, the rest keep old data.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
      end
      return res;
   endfunction

   // Byte offset within a word plays no part in address matching.
   assign unused_s    = ^mem_addr[1:0];

   assign wr_hit_s    = mem_valid & mem_we & mem_ready;
   assign done_hit_s  = wr_hit_s && (mem_addr[31:2] == DONE_ADDR[31:2]) && (mem_wstrb == 4'hF);
   assign wd_expire_s = (wd_cnt_r == WD_LAST);

   // Word-address decode of the signature channels.
   always_comb begin
      chan_hit_s = '0;
      for (int i = 0; i < NUM_SIGS; i++) begin
         if (wr_hit_s && (mem_addr[31:2] == (SIG_BASE[31:2] + 30'(i)))) begin
            chan_hit_s[i] = 1'b1;
         end else begin
            chan_hit_s[i] = 1'b0;
         end
      end
   end

   // Per-channel verdict: enabled channels fail if never written or mismatched.
   always_comb begin
      mask_s = '0;
      for (int i = 0; i < NUM_SIGS; i++) begin
         if (sig_enable[i] && (!seen_r[i] || (shadow_r[i] != sig_expected[32*i +: 32]))) begin
            mask_s[i] = 1'b1;
         end else begin
            mask_s[i] = 1'b0;
         end
      end
   end

   // Shadow capture of signature writes; only active while the program runs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SIGS; i++) begin
            shadow_r[i] <= 32'h0000_0000;
         end
         seen_r <= '0;
      end else if (state_r == ST_RUN) begin
         for (int i = 0; i < NUM_SIGS; i++) begin
            if (chan_hit_s[i]) begin
               shadow_r[i] <= merge_bytes(shadow_r[i], mem_wdata, mem_wstrb);
               // An all-zero strobe transfers no data, so it does not count as a write.
               if (mem_wstrb != 4'h0) begin
                  seen_r[i] <= 1'b1;
               end
            end
         end
      end
   end

   // Verdict FSM with counters and sticky registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_RUN;
         wd_cnt_r    <= 32'd0;
         cycle_count <= '0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         timeout     <= 1'b0;
         bad_exit    <= 1'b0;
         fail_mask   <= '0;
      end else begin
         case (state_r)
            ST_RUN: begin
               cycle_count <= cycle_count + CNT_W'(1);
               wd_cnt_r    <= wd_cnt_r + 32'd1;
               // A done write beats a watchdog expiry in the same cycle.
               if (done_hit_s) begin
                  if (mem_wdata == 32'd1) begin
                     state_r <= ST_CHECK;
                  end else begin
                     state_r  <= ST_FAIL;
                     done     <= 1'b1;
                     fail     <= 1'b1;
                     bad_exit <= 1'b1;
                  end
               end else if (wd_expire_s) begin
                  state_r <= ST_FAIL;
                  done    <= 1'b1;
                  fail    <= 1'b1;
                  timeout <= 1'b1;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_CHECK: begin
               fail_mask <= mask_s;
               done      <= 1'b1;
               if (mask_s == '0) begin
                  state_r <= ST_PASS;
                  pass    <= 1'b1;
               end else begin
                  state_r <= ST_FAIL;
                  fail    <= 1'b1;
               end
            end
            ST_PASS: begin
               state_r <= ST_PASS;
            end
            ST_FAIL: begin
               state_r <= ST_FAIL;
            end
            default: begin
               state_r <= ST_FAIL;
               done    <= 1'b1;
               fail    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tiny_sig_monitor.sv
// -----------------------------------------------------------------------------
// tb_tiny_sig_monitor
// Self-checking bench for tiny_sig_monitor (NUM_SIGS=4, TIMEOUT_CYCLES=50).
// A table of single-write-then-done scenarios is applied in a loop, followed
// by hand-written sequences for partial strobes, watchdog expiry, bad exit
// codes, the done/expiry tie and reset from a terminal state.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_tiny_sig_monitor;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_valid;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic [3:0]   mem_wstrb;
   logic         mem_ready;
   logic [127:0] sig_expected;
   logic [3:0]   sig_enable;
   logic         done;
   logic         pass;
   logic         fail;
   logic         timeout;
   logic         bad_exit;
   logic [3:0]   fail_mask;
   logic [31:0]  cycle_count;

   int errors = 0;
   int checks = 0;

   tiny_sig_monitor #(
      .NUM_SIGS       (4),
      .SIG_BASE       (32'h0000_0100),
      .DONE_ADDR      (32'h0000_01FC),
      .TIMEOUT_CYCLES (50),
      .CNT_W          (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_valid    (mem_valid),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb),
      .mem_ready    (mem_ready),
      .sig_expected (sig_expected),
      .sig_enable   (sig_enable),
      .done         (done),
      .pass         (pass),
      .fail         (fail),
      .timeout      (timeout),
      .bad_exit     (bad_exit),
      .fail_mask    (fail_mask),
      .cycle_count  (cycle_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic        we;
      logic        ready;
      logic [31:0] done_data;
      logic [3:0]  en;
      logic        exp_pass;
      logic        exp_fail;
      logic        exp_bad;
      logic [3:0]  exp_mask;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic e_done, input logic e_pass,
                             input logic e_fail, input logic e_to, input logic e_bad,
                             input logic [3:0] e_mask, input logic [31:0] e_cnt);
      check({tag, ".done"},        done,        e_done);
      check({tag, ".pass"},        pass,        e_pass);
      check({tag, ".fail"},        fail,        e_fail);
      check({tag, ".timeout"},     timeout,     e_to);
      check({tag, ".bad_exit"},    bad_exit,    e_bad);
      check({tag, ".fail_mask"},   fail_mask,   e_mask);
      check({tag, ".cycle_count"}, cycle_count, e_cnt);
   endtask

   // All tasks start and end at a falling edge.
   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic we = 1'b1,
                            input logic ready = 1'b1);
      mem_valid = 1'b1;
      mem_we    = we;
      mem_addr  = addr;
      mem_wdata = data;
      mem_wstrb = strb;
      mem_ready = ready;
      @(negedge clk);
      mem_valid = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      mem_wstrb = 4'h0;
      mem_ready = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      mem_valid    = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = 32'h0;
      mem_wdata    = 32'h0;
      mem_wstrb    = 4'h0;
      mem_ready    = 1'b0;
      // ch3=0, ch2=0, ch1=0x1122AA44, ch0=10
      sig_expected = {32'h0000_0000, 32'h0000_0000, 32'h1122_AA44, 32'd10};
      sig_enable   = 4'b0001;

      //           addr          data          strb  we    rdy   done   en      pass  fail  bad   mask
      vecs[0]  = '{32'h100, 32'd10,       4'hF, 1'b1, 1'b1, 32'd1, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000};
      vecs[1]  = '{32'h100, 32'd10,       4'hF, 1'b1, 1'b1, 32'd1, 4'b0011, 1'b0, 1'b1, 1'b0, 4'b0010};
      vecs[2]  = '{32'h102, 32'd10,       4'hF, 1'b1, 1'b1, 32'd1, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000};
      vecs[3]  = '{32'h100, 32'd10,       4'hF, 1'b0, 1'b1, 32'd1, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0001};
      vecs[4]  = '{32'h100, 32'd10,       4'hF, 1'b1, 1'b0, 32'd1, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0001};
      vecs[5]  = '{32'h108, 32'd0,        4'h0, 1'b1, 1'b1, 32'd1, 4'b0100, 1'b0, 1'b1, 1'b0, 4'b0100};
      vecs[6]  = '{32'h108, 32'd0,        4'hF, 1'b1, 1'b1, 32'd1, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000};
      vecs[7]  = '{32'h10C, 32'd5,        4'hF, 1'b1, 1'b1, 32'd1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};
      vecs[8]  = '{32'h100, 32'd10,       4'hF, 1'b1, 1'b1, 32'd3, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0000};
      vecs[9]  = '{32'h100, 32'd10,       4'hF, 1'b1, 1'b1, 32'd0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0000};
      vecs[10] = '{32'h110, 32'd10,       4'hF, 1'b1, 1'b1, 32'd1, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0001};

      // Reset state
      @(negedge clk);
      do_reset();
      check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd0);
      idle(3);
      check("run_count", cycle_count, 32'd3);

      // Table: reset, one bus cycle, done write, one CHECK cycle.
      // RUN edges: write (1) + done write (2); CHECK does not count.
      for (int k = 0; k < 11; k++) begin
         sig_enable = vecs[k].en;
         do_reset();
         bus_write(vecs[k].addr, vecs[k].data, vecs[k].strb, vecs[k].we, vecs[k].ready);
         bus_write(32'h1FC, vecs[k].done_data, 4'hF);
         idle(1);
         check_outs($sformatf("vec%0d", k), 1'b1, vecs[k].exp_pass, vecs[k].exp_fail,
                    1'b0, vecs[k].exp_bad, vecs[k].exp_mask, 32'd2);
      end

      // Byte-strobe merge plus a partial-strobe done write that must be ignored.
      sig_enable = 4'b0010;
      do_reset();
      bus_write(32'h104, 32'h1122_3344, 4'hF);
      bus_write(32'h104, 32'h0000_AA00, 4'b0010);
      bus_write(32'h1FC, 32'd1, 4'b0001);
      idle(2);
      check("partial_done.done", done, 1'b0);
      check("partial_done.count", cycle_count, 32'd5);
      bus_write(32'h1FC, 32'd1, 4'hF);
      idle(1);
      check_outs("strb_merge", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd6);

      // Watchdog: 49 RUN cycles still running, the 50th expires.
      sig_enable = 4'b0001;
      do_reset();
      idle(49);
      check("wd_pre.done", done, 1'b0);
      check("wd_pre.count", cycle_count, 32'd49);
      idle(1);
      check_outs("wd_expire", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 32'd50);
      idle(10);
      check("wd_frozen.count", cycle_count, 32'd50);

      // Bad exit code, then a later good done write must not change the verdict.
      do_reset();
      bus_write(32'h1FC, 32'd3, 4'hF);
      check_outs("bad_exit", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 32'd1);
      bus_write(32'h1FC, 32'd1, 4'hF);
      idle(2);
      check_outs("bad_exit_hold", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 32'd1);

      // Done write on the watchdog-expiry cycle wins, then reset from PASS.
      sig_enable = 4'b0001;
      do_reset();
      bus_write(32'h100, 32'd10, 4'hF);
      idle(48);
      bus_write(32'h1FC, 32'd1, 4'hF);
      idle(1);
      check_outs("tie", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd50);
      do_reset();
      check_outs("reset_pass", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
